// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the CHIP-8 unified memory arbiter.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package mem_arbiter_pkg;

   localparam int MEM_BYTES = 4096;

   typedef enum logic [2:0] {
      IDLE,
      RD,
      I_LO,
      I_WAIT,
      ACK
   } arb_state_t;

   typedef enum logic [1:0] {
      REQ_I = 2'd0,
      REQ_D = 2'd1,
      REQ_V = 2'd2
   } req_id_t;

   // Cyclic successor in the I -> D -> V -> I service order.
   function automatic req_id_t next_id(input req_id_t id);
      case (id)
         REQ_I:   return REQ_D;
         REQ_D:   return REQ_V;
         default: return REQ_I;
      endcase
   endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester-side bundle: instruction fetch (I), CPU data (D) and video (V) ports.
// Latency: n/a (wiring only).
// Backpressure: req/ack handshake; each requester holds req until its one-cycle ack.
// Ports: i_* 16-bit fetch, d_* byte read/write, v_* byte read; slave = arbiter view.
interface mem_arbiter_if;

   logic        i_req;
   logic [15:0] i_adr;
   logic        i_ack;
   logic [15:0] i_rdata;

   logic        d_req;
   logic        d_we;
   logic [15:0] d_adr;
   logic [7:0]  d_wdata;
   logic        d_ack;
   logic [7:0]  d_rdata;

   logic        v_req;
   logic [15:0] v_adr;
   logic        v_ack;
   logic [7:0]  v_rdata;

   modport slave (
      input  i_req, i_adr, d_req, d_we, d_adr, d_wdata, v_req, v_adr,
      output i_ack, i_rdata, d_ack, d_rdata, v_ack, v_rdata
   );

   modport master (
      output i_req, i_adr, d_req, d_we, d_adr, d_wdata, v_req, v_adr,
      input  i_ack, i_rdata, d_ack, d_rdata, v_ack, v_rdata
   );

endinterface

// File: rtl/mem_arbiter_rr_pick.sv
// Round-robin (or fixed-priority) picker over the three requesters.
// Latency: purely combinational.
// Backpressure: none; losers simply stay unselected.
// Ports: req[2:0] = {V,D,I}, ptr = first requester to consider; gnt one-hot, gnt_id encoded.
module rr_pick
   import mem_arbiter_pkg::*;
#(
   parameter bit FAIR = 1'b1
) (
   input  logic [2:0] req,
   input  req_id_t    ptr,
   output logic [2:0] gnt,
   output req_id_t    gnt_id
);

   req_id_t cand;

   // Walk the cyclic order starting at the pointer; the first active request wins.
   // Fixed priority is just the same walk always starting at I.
   always_comb begin
      gnt    = '0;
      gnt_id = REQ_I;
      cand   = FAIR ? ptr : REQ_I;
      for (int k = 0; k < 3; k++) begin
         if (gnt == 3'b000 && req[cand]) begin
            gnt[cand] = 1'b1;
            gnt_id    = cand;
         end
         cand = next_id(cand);
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one byte-wide registered RAM between I fetch (2 bytes), D read/write and V read.
// Latency from grant cycle N: write ack N+1, byte read ack N+2, fetch ack N+3.
// Backpressure: requesters hold req until ack; only IDLE samples requests, one ack per cycle.
// Ports: clk/rst (sync, active high), bus (requester interface), mem_* to the RAM.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int ADDR_W = 12,
   parameter bit FAIR   = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   mem_arbiter_if.slave      bus,
   output logic [ADDR_W-1:0] mem_adr,
   output logic              mem_we,
   output logic [7:0]        mem_wdata,
   input  logic [7:0]        mem_rdata
);

   arb_state_t        state, state_nxt;
   req_id_t           ptr, win;
   req_id_t           gnt_id;
   logic [2:0]        req_vec, gnt;
   logic              any_gnt;
   logic [ADDR_W-1:0] adr_q, sel_adr;
   logic [7:0]        hi_q;
   logic [15:0]       i_rdata_q;
   logic [7:0]        d_rdata_q, v_rdata_q;
   logic              unused_hi;

   assign req_vec = {bus.v_req, bus.d_req, bus.i_req};
   assign any_gnt = |gnt;

   rr_pick #(.FAIR(FAIR)) u_pick (
      .req    (req_vec),
      .ptr    (ptr),
      .gnt    (gnt),
      .gnt_id (gnt_id)
   );

   // Requester addresses alias modulo the RAM size; upper bits are dropped.
   always_comb begin
      case (gnt_id)
         REQ_D:   sel_adr = bus.d_adr[ADDR_W-1:0];
         REQ_V:   sel_adr = bus.v_adr[ADDR_W-1:0];
         default: sel_adr = bus.i_adr[ADDR_W-1:0];
      endcase
   end

   assign unused_hi = ^{bus.i_adr[15:ADDR_W], bus.d_adr[15:ADDR_W], bus.v_adr[15:ADDR_W]};

   // Next state and RAM drive. The grant cycle itself drives the RAM so a write
   // completes in IDLE and reads start one cycle earlier.
   always_comb begin
      state_nxt = state;
      mem_adr   = '0;
      mem_we    = 1'b0;
      mem_wdata = '0;
      case (state)
         IDLE: begin
            if (any_gnt) begin
               mem_adr = sel_adr;
               if (gnt_id == REQ_D && bus.d_we) begin
                  mem_we    = 1'b1;
                  mem_wdata = bus.d_wdata;
                  state_nxt = ACK;
               end else if (gnt_id == REQ_I) begin
                  state_nxt = I_LO;
               end else begin
                  state_nxt = RD;
               end
            end
         end
         RD: begin
            mem_adr   = adr_q;
            state_nxt = ACK;
         end
         // Second fetch byte wraps naturally at the top of the address space.
         I_LO: begin
            mem_adr   = adr_q + ADDR_W'(1);
            state_nxt = I_WAIT;
         end
         I_WAIT: begin
            mem_adr   = adr_q + ADDR_W'(1);
            state_nxt = ACK;
         end
         ACK: begin
            mem_adr   = adr_q;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
      // A write granted in a reset cycle must never reach the RAM.
      if (rst) begin
         mem_adr   = '0;
         mem_we    = 1'b0;
         mem_wdata = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         ptr       <= REQ_I;
         win       <= REQ_I;
         adr_q     <= '0;
         hi_q      <= '0;
         i_rdata_q <= '0;
         d_rdata_q <= '0;
         v_rdata_q <= '0;
      end else begin
         state <= state_nxt;
         case (state)
            IDLE: begin
               if (any_gnt) begin
                  win   <= gnt_id;
                  adr_q <= sel_adr;
               end
            end
            RD: begin
               if (win == REQ_V) v_rdata_q <= mem_rdata;
               else              d_rdata_q <= mem_rdata;
            end
            // Stage the high byte so i_rdata only changes when the fetch completes.
            I_LO:   hi_q      <= mem_rdata;
            I_WAIT: i_rdata_q <= {hi_q, mem_rdata};
            ACK: begin
               if (FAIR) ptr <= next_id(win);
            end
            default: ;
         endcase
      end
   end

   assign bus.i_ack   = !rst && state == ACK && win == REQ_I;
   assign bus.d_ack   = !rst && state == ACK && win == REQ_D;
   assign bus.v_ack   = !rst && state == ACK && win == REQ_V;
   assign bus.i_rdata = i_rdata_q;
   assign bus.d_rdata = d_rdata_q;
   assign bus.v_rdata = v_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: FAIR=1 instance with a registered RAM model,
// plus a FAIR=0 instance used only to confirm fixed priority starvation.
module tb_mem_arbiter;
   import mem_arbiter_pkg::*;

   logic        clk;
   logic        rst;
   logic [11:0] mem_adr;
   logic        mem_we;
   logic [7:0]  mem_wdata;
   logic [7:0]  mem_rdata;

   logic [11:0] unused_adr2;
   logic        unused_we2;
   logic [7:0]  unused_wdata2;
   logic [7:0]  mem_rdata2;

   logic        pre_we;
   logic [11:0] pre_adr;
   logic [7:0]  pre_dat;

   logic [7:0]  ram [0:MEM_BYTES-1];

   int checks;
   int errors;
   int i_cnt2;
   logic [2:0] exp_ack;

   mem_arbiter_if bus ();
   mem_arbiter_if bus2 ();

   mem_arbiter #(.ADDR_W(12), .FAIR(1'b1)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .mem_adr   (mem_adr),
      .mem_we    (mem_we),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata)
   );

   mem_arbiter #(.ADDR_W(12), .FAIR(1'b0)) dut_fix (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus2),
      .mem_adr   (unused_adr2),
      .mem_we    (unused_we2),
      .mem_wdata (unused_wdata2),
      .mem_rdata (mem_rdata2)
   );

   assign mem_rdata2 = 8'h00;

   always #5 clk = ~clk;

   // Registered single-port RAM; the preload port lets the bench seed contents.
   always @(posedge clk) begin
      if (pre_we) ram[pre_adr] <= pre_dat;
      if (mem_we) ram[mem_adr] <= mem_wdata;
      mem_rdata <= ram[mem_adr];
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   task automatic preload(input logic [11:0] a, input logic [7:0] d);
      pre_we  = 1'b1;
      pre_adr = a;
      pre_dat = d;
      cyc();
      pre_we  = 1'b0;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      clk = 1'b0;
      rst = 1'b1;
      checks = 0;
      errors = 0;
      i_cnt2 = 0;
      pre_we = 1'b0;
      pre_adr = '0;
      pre_dat = '0;
      bus.i_req = 0; bus.i_adr = '0;
      bus.d_req = 0; bus.d_we = 0; bus.d_adr = '0; bus.d_wdata = '0;
      bus.v_req = 0; bus.v_adr = '0;
      bus2.i_req = 0; bus2.i_adr = '0;
      bus2.d_req = 0; bus2.d_we = 0; bus2.d_adr = '0; bus2.d_wdata = '0;
      bus2.v_req = 0; bus2.v_adr = '0;

      cyc();
      preload(12'h200, 8'hA2);
      preload(12'h201, 8'h1E);
      preload(12'hFFF, 8'h12);
      preload(12'h000, 8'h34);
      preload(12'h020, 8'h11);

      // Reset state
      smp();
      chk("rst_acks",    32'({bus.v_ack, bus.d_ack, bus.i_ack}), 0);
      chk("rst_mem_we",  32'(mem_we), 0);
      chk("rst_mem_adr", 32'(mem_adr), 0);
      chk("rst_wdata",   32'(mem_wdata), 0);
      chk("rst_i_rdata", 32'(bus.i_rdata), 0);
      chk("rst_d_rdata", 32'(bus.d_rdata), 0);
      chk("rst_v_rdata", 32'(bus.v_rdata), 0);

      // Fetch 0x200: two RAM addresses, ack three cycles after grant
      cyc();
      rst = 1'b0;
      bus.i_req = 1'b1; bus.i_adr = 16'h0200;
      smp();
      chk("fetch_adr_hi", 32'(mem_adr), 'h200);
      chk("fetch_no_we",  32'(mem_we), 0);
      cyc(); smp();
      chk("fetch_adr_lo", 32'(mem_adr), 'h201);
      chk("fetch_ack_n1", 32'(bus.i_ack), 0);
      cyc(); smp();
      chk("fetch_ack_n2", 32'(bus.i_ack), 0);
      cyc(); smp();
      chk("fetch_ack_n3", 32'(bus.i_ack), 1);
      chk("fetch_rdata",  32'(bus.i_rdata), 'hA21E);
      bus.i_req = 1'b0;
      cyc(); smp();
      chk("fetch_ack_off", 32'(bus.i_ack), 0);
      chk("fetch_held",    32'(bus.i_rdata), 'hA21E);

      // Data write 0x5C to 0x300, then read it back
      cyc();
      bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_adr = 16'h0300; bus.d_wdata = 8'h5C;
      smp();
      chk("wr_we",    32'(mem_we), 1);
      chk("wr_adr",   32'(mem_adr), 'h300);
      chk("wr_wdata", 32'(mem_wdata), 'h5C);
      chk("wr_ack_n", 32'(bus.d_ack), 0);
      cyc(); smp();
      chk("wr_ack_n1", 32'(bus.d_ack), 1);
      chk("wr_we_one", 32'(mem_we), 0);
      bus.d_req = 1'b0;
      cyc();
      chk("wr_ram", 32'(ram[12'h300]), 'h5C);
      bus.d_req = 1'b1; bus.d_we = 1'b0;
      smp();
      chk("rd_adr", 32'(mem_adr), 'h300);
      chk("rd_we",  32'(mem_we), 0);
      cyc(); smp();
      chk("rd_ack_n1", 32'(bus.d_ack), 0);
      cyc(); smp();
      chk("rd_ack_n2", 32'(bus.d_ack), 1);
      chk("rd_rdata",  32'(bus.d_rdata), 'h5C);
      bus.d_req = 1'b0;

      // Contention from reset release: I, D, V, then I again
      cyc();
      rst = 1'b1;
      bus.i_req = 1'b1; bus.i_adr = 16'h0200;
      bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_adr = 16'h0300;
      bus.v_req = 1'b1; bus.v_adr = 16'h1200;
      cyc();
      rst = 1'b0;
      for (int k = 0; k < 14; k++) begin
         smp();
         exp_ack = (k == 3 || k == 13) ? 3'b001 :
                   (k == 6)            ? 3'b010 :
                   (k == 9)            ? 3'b100 : 3'b000;
         chk($sformatf("rr_acks_c%0d", k), 32'({bus.v_ack, bus.d_ack, bus.i_ack}), 32'(exp_ack));
         if (k == 0)  chk("rr_i_cleared", 32'(bus.i_rdata), 0);
         if (k == 4)  chk("rr_d_adr",     32'(mem_adr), 'h300);
         if (k == 6)  chk("rr_d_rdata",   32'(bus.d_rdata), 'h5C);
         if (k == 7)  chk("alias_v_adr",  32'(mem_adr), 'h200);
         if (k == 9)  chk("alias_v_rdata", 32'(bus.v_rdata), 'hA2);
         if (k == 13) chk("rr_i_rdata",   32'(bus.i_rdata), 'hA21E);
         cyc();
      end
      bus.i_req = 1'b0; bus.d_req = 1'b0; bus.v_req = 1'b0;

      // Wrap-around fetch at 0xFFF
      bus.i_req = 1'b1; bus.i_adr = 16'h0FFF;
      smp();
      chk("wrap_adr_hi", 32'(mem_adr), 'hFFF);
      cyc(); smp();
      chk("wrap_adr_lo", 32'(mem_adr), 'h000);
      cyc(); cyc(); smp();
      chk("wrap_ack",   32'(bus.i_ack), 1);
      chk("wrap_rdata", 32'(bus.i_rdata), 'h1234);
      bus.i_req = 1'b0;
      cyc();

      // Reset in the I_LO cycle of a fetch, with a write pending
      bus.i_req = 1'b1; bus.i_adr = 16'h0200;
      cyc();
      rst = 1'b1;
      bus.i_req = 1'b0;
      bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_adr = 16'h0010; bus.d_wdata = 8'h77;
      smp();
      chk("rstf_we",  32'(mem_we), 0);
      chk("rstf_ack", 32'(bus.i_ack), 0);
      cyc();
      rst = 1'b0;
      smp();
      chk("rstf_i_rdata", 32'(bus.i_rdata), 0);
      chk("rstf_i_ack",   32'(bus.i_ack), 0);
      chk("rstf_d_we",    32'(mem_we), 1);
      chk("rstf_d_adr",   32'(mem_adr), 'h010);
      cyc(); smp();
      chk("rstf_d_ack",   32'(bus.d_ack), 1);
      chk("rstf_i_ack2",  32'(bus.i_ack), 0);
      bus.d_req = 1'b0;
      cyc();
      chk("rstf_ram", 32'(ram[12'h010]), 'h77);
      smp();
      chk("rstf_i_ack3", 32'(bus.i_ack), 0);

      // Reset during a write grant: no RAM write
      cyc();
      rst = 1'b1;
      bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_adr = 16'h0020; bus.d_wdata = 8'hEE;
      smp();
      chk("rstw_we",    32'(mem_we), 0);
      chk("rstw_wdata", 32'(mem_wdata), 0);
      cyc(); smp();
      chk("rstw_ram",   32'(ram[12'h020]), 'h11);
      chk("rstw_d_ack", 32'(bus.d_ack), 0);
      bus.d_req = 1'b0;
      cyc();
      rst = 1'b0;

      // Fixed priority: I held starves D and V
      cyc();
      bus2.i_req = 1'b1; bus2.i_adr = 16'h0040;
      bus2.d_req = 1'b1; bus2.d_adr = 16'h0050;
      bus2.v_req = 1'b1; bus2.v_adr = 16'h0060;
      for (int k = 0; k < 16; k++) begin
         smp();
         chk($sformatf("fix_dv_c%0d", k), 32'({bus2.v_ack, bus2.d_ack}), 0);
         if (bus2.i_ack) i_cnt2++;
         cyc();
      end
      chk("fix_i_acks", 32'(i_cnt2), 4);
      bus2.i_req = 1'b0; bus2.d_req = 1'b0; bus2.v_req = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
